// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time, hands {pc, inst} to decode.
// Optional build macro IFU_PERF_CNT_EN adds fetch/stall performance counters.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt
`endif
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] inst_reg;
  logic        drop;
  logic        req_hs;
  logic [31:0] redir_tgt;

  assign redir_tgt = redirect_pc & ~32'h3;
  assign req_hs    = (state == S_REQ) && imem_req_ready;

  assign imem_req_valid = !rst && (state == S_REQ);
  assign inst_valid     = !rst && (state == S_HOLD);
  assign imem_req_addr  = rst ? 32'h0 : pc;
  assign inst_pc        = rst ? 32'h0 : pc;
  assign inst           = rst ? 32'h0 : inst_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      inst_reg <= 32'h0;
    end else begin
      case (state)
        S_REQ: begin
          // a redirect racing the handshake leaves a wrong-path read in flight
          if (req_hs) begin
            state <= S_WAIT;
            drop  <= redirect_valid;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            drop <= 1'b0;
            if (drop || redirect_valid) state <= S_REQ;
            else begin
              inst_reg <= imem_resp_data;
              state    <= S_HOLD;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid || inst_ready) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
      if (redirect_valid)                   pc <= redir_tgt;
      else if (state == S_HOLD && inst_ready) pc <= pc + 32'd4;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [63:0] fetch_cnt_q;
  logic [63:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 64'h0;
      stall_cnt_q <= 64'h0;
    end else begin
      if (state == S_HOLD && inst_ready) fetch_cnt_q <= fetch_cnt_q + 64'd1;
      if ((state == S_REQ && !imem_req_ready) || (state == S_WAIT && !imem_resp_valid))
        stall_cnt_q <= stall_cnt_q + 64'd1;
    end
  end

  assign perf_fetch_cnt = rst ? 64'h0 : fetch_cnt_q;
  assign perf_stall_cnt = rst ? 64'h0 : stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios then random traffic, checked against a transaction-level
// model (expected PC, outstanding-read memory, handshake counters).
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc), .inst(inst)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // stimulus knobs
  logic        rnd, ready_cfg, irdy_cfg;
  int          lat_cfg;
  int          redir_mode;      // 0 none, 1 now, 2 with next resp, 3 with next req handshake
  logic [31:0] redir_tgt;
  logic        ovr_en;
  logic [31:0] ovr_data;

  // reference model state
  logic [31:0] exp_pc;
  logic        outstanding;
  logic [31:0] out_addr;
  int          cnt;
  int          cyc;
  longint      fetch_cnt, stall_cnt;
  logic [31:0] req_addr_q[$];
  int          req_cyc_q[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, check outputs, update model at posedge, return at negedge.
  task automatic tick();
    logic hs_req, hs_inst, fire, stall, rv;
    logic [31:0] a, tgt;
    imem_req_ready  = rnd ? ($urandom_range(0, 3) != 0) : ready_cfg;
    inst_ready      = rnd ? ($urandom_range(0, 1) == 1) : irdy_cfg;
    imem_resp_valid = outstanding && (cnt == 0);
    imem_resp_data  = ovr_en ? ovr_data : memf(out_addr);
    rv  = 1'b0;
    tgt = redir_tgt;
    case (redir_mode)
      1: rv = 1'b1;
      2: rv = imem_resp_valid;
      3: rv = imem_req_valid && imem_req_ready;
      default: rv = 1'b0;
    endcase
    if (rv) redir_mode = 0;
    if (rnd && $urandom_range(0, 15) == 0) begin
      rv  = 1'b1;
      tgt = $urandom;
    end
    redirect_valid = rv;
    redirect_pc    = rv ? tgt : $urandom;
    #1;
    if (rst) begin
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_inst_valid", inst_valid, 0);
    end else begin
      if (imem_req_valid) begin
        chk("req_addr", imem_req_addr, exp_pc);
        chk("req_while_outstanding", outstanding, 0);
      end
      if (inst_valid) begin
        chk("inst_pc", inst_pc, exp_pc);
        chk("inst_data", inst, memf(exp_pc));
        chk("inst_while_busy", outstanding || imem_req_valid, 0);
      end
`ifdef IFU_PERF_CNT_EN
      chk("perf_fetch", perf_fetch_cnt, fetch_cnt);
      chk("perf_stall", perf_stall_cnt, stall_cnt);
`endif
    end
    hs_req  = !rst && imem_req_valid && imem_req_ready;
    hs_inst = !rst && inst_valid && inst_ready;
    fire    = imem_resp_valid;
    stall   = !rst && ((imem_req_valid && !imem_req_ready) || (outstanding && !imem_resp_valid));
    a       = imem_req_addr;
    @(posedge clk);
    if (rst) begin
      exp_pc = RESET_PC;
      outstanding = 1'b0;
      ovr_en = 1'b0;
      fetch_cnt = 0;
      stall_cnt = 0;
    end else begin
      if (fire) begin
        outstanding = 1'b0;
        ovr_en = 1'b0;
      end else if (outstanding && cnt != 0) cnt--;
      if (hs_req) begin
        outstanding = 1'b1;
        out_addr = a;
        cnt = rnd ? int'($urandom_range(0, 3)) : lat_cfg;
        req_addr_q.push_back(a);
        req_cyc_q.push_back(cyc);
      end
      if (rv)           exp_pc = tgt & ~32'h3;
      else if (hs_inst) exp_pc = exp_pc + 32'd4;
      if (hs_inst) fetch_cnt++;
      if (stall)   stall_cnt++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_req_valid", imem_req_valid, 1);
    chk("post_rst_req_addr", imem_req_addr, RESET_PC);
    chk("post_rst_inst_valid", inst_valid, 0);
    req_addr_q.delete();
    req_cyc_q.delete();
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (req_addr_q.size() == 0 && n < 30) begin tick(); n++; end
    chk(tag, req_addr_q.size() > 0, 1);
  endtask

  task automatic wait_inst(input string tag);
    int n = 0;
    while (!inst_valid && n < 30) begin tick(); n++; end
    chk(tag, inst_valid, 1);
  endtask

  initial begin
    logic [31:0] pc0, d0;
    longint f0;
    int n;
    rst = 1'b1; redirect_valid = 0; redirect_pc = 0; imem_req_ready = 0;
    imem_resp_valid = 0; imem_resp_data = 0; inst_ready = 0;
    rnd = 0; ready_cfg = 1; irdy_cfg = 1; lat_cfg = 0; redir_mode = 0; redir_tgt = 0;
    ovr_en = 0; ovr_data = 0; exp_pc = RESET_PC; outstanding = 0; out_addr = 0; cnt = 0;
    cyc = 0; fetch_cnt = 0; stall_cnt = 0;
    @(negedge clk);
    do_reset();

    // back-to-back fetches at 3-cycle spacing
    n = 0;
    while (req_addr_q.size() < 3 && n < 20) begin tick(); n++; end
    chk("t1_req_count", req_addr_q.size(), 3);
    if (req_addr_q.size() >= 3) begin
      chk("t1_addr0", req_addr_q[0], 32'h8000_0000);
      chk("t1_addr1", req_addr_q[1], 32'h8000_0004);
      chk("t1_addr2", req_addr_q[2], 32'h8000_0008);
      chk("t1_gap01", req_cyc_q[1] - req_cyc_q[0], 3);
      chk("t1_gap12", req_cyc_q[2] - req_cyc_q[1], 3);
    end

    // decode backpressure in HOLD
    irdy_cfg = 0;
    wait_inst("t2_inst_valid");
    pc0 = inst_pc; d0 = inst;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", inst_valid, 1);
      chk("t2_hold_pc", inst_pc, pc0);
      chk("t2_hold_inst", inst, d0);
      chk("t2_no_req", imem_req_valid, 0);
    end
    irdy_cfg = 1;
    req_addr_q.delete();
    wait_req("t2_next_req");
    if (req_addr_q.size() > 0) chk("t2_next_addr", req_addr_q[0], pc0 + 32'd4);

    // redirect while waiting; late bad response must never reach decode
    lat_cfg = 2;
    n = 0;
    while (!outstanding && n < 20) begin tick(); n++; end
    chk("t3_in_wait", outstanding, 1);
    ovr_en = 1; ovr_data = 32'hDEAD_BEEF;
    redir_mode = 1; redir_tgt = 32'h8000_1002;
    tick();
    lat_cfg = 0;
    req_addr_q.delete();
    n = 0;
    while (req_addr_q.size() == 0 && n < 20) begin
      chk("t3_no_inst", inst_valid, 0);
      tick(); n++;
    end
    chk("t3_req_seen", req_addr_q.size() > 0, 1);
    if (req_addr_q.size() > 0) chk("t3_addr", req_addr_q[0], 32'h8000_1000);

    // redirect coinciding with the response
    lat_cfg = 1;
    n = 0;
    while (!outstanding && n < 20) begin tick(); n++; end
    redir_mode = 2; redir_tgt = 32'h8000_0100;
    n = 0;
    while (redir_mode != 0 && n < 10) begin tick(); n++; end
    chk("t4_req_valid", imem_req_valid, 1);
    chk("t4_req_addr", imem_req_addr, 32'h8000_0100);
    wait_inst("t4_inst_valid");
    chk("t4_inst_pc", inst_pc, 32'h8000_0100);
    chk("t4_inst", inst, memf(32'h8000_0100));
    lat_cfg = 0;

    // redirect racing a request handshake
    n = 0;
    while (!imem_req_valid && n < 20) begin tick(); n++; end
    redir_mode = 3; redir_tgt = 32'h8000_0200;
    tick();
    chk("t5_no_inst_a", inst_valid, 0);
    tick();
    chk("t5_no_inst_b", inst_valid, 0);
    chk("t5_req_valid", imem_req_valid, 1);
    chk("t5_req_addr", imem_req_addr, 32'h8000_0200);
    wait_inst("t5_inst_valid");
    chk("t5_inst_pc", inst_pc, 32'h8000_0200);

    // PC wraparound
    redir_mode = 1; redir_tgt = 32'hFFFF_FFFC;
    n = 0;
    while (!(inst_valid && inst_pc == 32'hFFFF_FFFC) && n < 30) begin tick(); n++; end
    chk("t6_top_inst", inst_pc, 32'hFFFF_FFFC);
    req_addr_q.delete();
    wait_req("t6_wrap_req");
    if (req_addr_q.size() > 0) chk("t6_wrap_addr", req_addr_q[0], 32'h0000_0000);

    // random traffic against the model
    f0 = fetch_cnt;
    rnd = 1;
    for (int i = 0; i < 800; i++) tick();
    rnd = 0;
    chk("rand_progress", (fetch_cnt - f0) > 40, 1);

    // reset in the middle of traffic
    do_reset();
    wait_inst("rst2_inst_valid");
    chk("rst2_inst_pc", inst_pc, RESET_PC);
`ifdef IFU_PERF_CNT_EN
    tick();
    chk("perf_final", perf_fetch_cnt, fetch_cnt);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage for the NPC core.
- Owns the architectural PC register, which resets to 0x80000000.
- Issues one instruction-memory read at a time over a valid/ready request channel and captures the response.
- Presents {pc, inst} to decode over a valid/ready channel; a redirect from execute/writeback re-steers the PC and squashes any in-flight fetch.

Parameters:
RESET_PC, 32'h80000000, PC value loaded on reset.

Ports:
clk  input  1  clock, all state updates on posedge.
rst  input  1  synchronous reset, active-high.
redirect_valid  input  1  re-steer request (branch/jump/trap).
redirect_pc  input  32  new fetch target; bits [1:0] ignored, forced to 00.
imem_req_valid  output  1  read request valid.
imem_req_ready  input  1  memory accepts request.
imem_req_addr  output  32  read address, equals current PC.
imem_resp_valid  input  1  read data valid; exactly one response per accepted request, no earlier than the next cycle.
imem_resp_data  input  32  read data.
inst_valid  output  1  fetched instruction valid to decode.
inst_ready  input  1  decode accepts instruction.
inst_pc  output  32  PC of the presented instruction.
inst  output  32  presented instruction word.

Behaviour:
- Reset: the state updated at the clock edge with rst=1 is pc=RESET_PC, state=REQ, drop=0, inst_reg=0.
  - While rst=1, imem_req_valid=0 and inst_valid=0; all outputs are gated by !rst.
  - First cycle after release: imem_req_valid=1, imem_req_addr=RESET_PC.
- States: REQ, WAIT, HOLD. imem_req_valid=(state==REQ); inst_valid=(state==HOLD); imem_req_addr=pc; inst_pc=pc; inst=inst_reg.
- REQ:
  - req handshake (valid & ready) -> WAIT.
  - Otherwise stay in REQ and hold the address stable.
- WAIT:
  - imem_resp_valid & !drop -> latch inst_reg, go to HOLD.
  - imem_resp_valid & drop -> discard the data, clear drop, go to REQ.
- HOLD:
  - inst_ready -> pc <= pc+4 (mod 2^32, so 0xFFFFFFFC wraps to 0x00000000), go to REQ.
  - Otherwise hold pc and inst stable.
- Redirect has highest priority; pc <= {redirect_pc[31:2],2'b00} in every state.
  - REQ, no handshake: stay in REQ; the new address appears the next cycle.
  - REQ with a same-cycle req handshake: go to WAIT with drop=1, since the request for the old address is in flight.
  - WAIT without resp: set drop=1 and stay in WAIT.
  - WAIT with a same-cycle resp: discard the data, drop=0, go to REQ.
  - HOLD: go to REQ, discarding inst_reg. If inst_ready is high in the same cycle, the handshake still counts; decode squashes wrong-path instructions and this block does not retract.
- At most one outstanding request; the request channel is never re-asserted while in WAIT.
- Minimum latency: req handshake in cycle N, resp in N+1, inst_valid in N+2, next request in N+3 if accepted in N+2. Peak throughput is 1 instruction per 3 cycles.
- Reset mid-operation: returns to REQ at RESET_PC. A response arriving after reset for a pre-reset request is a memory-side protocol violation and is not handled.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- When defined, the block adds two outputs:
  - perf_fetch_cnt[63:0]: increments on each inst handshake.
  - perf_stall_cnt[63:0]: increments each cycle with (state==REQ & !imem_req_ready) or (state==WAIT & !imem_resp_valid).
  - Both counters reset to 0 on rst and wrap at 2^64.
- When undefined, neither the ports nor the counter logic exists; all other behaviour is identical.

Test Plan:
- Reset release, memory always ready, resp next cycle, inst_ready=1 -> request addresses 0x80000000, 0x80000004, 0x80000008 at 3-cycle spacing; inst_pc matches; inst matches returned data.
- Hold inst_ready=0 for 5 cycles while in HOLD -> inst_valid stays 1; inst/inst_pc stable; no new request. Then inst_ready=1 -> next request at pc+4.
- Redirect to 0x80001002 in WAIT, resp 2 cycles later with 0xDEADBEEF -> data never reaches inst_valid; next request addr 0x80001000.
- Redirect to 0x80000100 in the same cycle as imem_resp_valid -> response dropped; next cycle REQ with addr 0x80000100; no stale drop on the following fetch.
- Redirect in REQ with a simultaneous req handshake, target 0x80000200 -> the response for the old address is discarded; a fresh request for 0x80000200 follows.
- PC redirected to 0xFFFFFFFC, instruction accepted -> next request addr 0x00000000. With IFU_PERF_CNT_EN defined, perf_fetch_cnt equals the number of inst handshakes counted.
